// File: rtl/fib_job_scheduler.sv
// Two-requester Fibonacci job scheduler: a round-robin grant feeds one iterative F(n) engine.
// Optional sticky wrap detection on the result is enabled with `define FIB_OVF_DETECT_EN.
module fib_job_scheduler #(
  parameter int W  = 16,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic [NW-1:0] a_req_n,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic [NW-1:0] b_req_n,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_data,
  output logic          busy
`ifdef FIB_OVF_DETECT_EN
  ,
  output logic          rsp_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t        state_q, state_d;
  logic          id_q, id_d;
  logic          last_q, last_d;  // 1 = B served last, so A wins the first tie
  logic [NW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          grant_a, grant_b;
  logic [W:0]    sum;
`ifdef FIB_OVF_DETECT_EN
  logic          xt_q, xt_d;
  logic          yt_q, yt_d;
  logic          rsp_ovf_q, rsp_ovf_d;
`endif

  assign sum     = {1'b0, x_q} + {1'b0, y_q};
  assign grant_a = a_req_valid && (!b_req_valid || last_q);
  assign grant_b = b_req_valid && (!a_req_valid || !last_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
`ifdef FIB_OVF_DETECT_EN
    xt_d        = xt_q;
    yt_d        = yt_q;
    rsp_ovf_d   = rsp_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        a_req_ready = grant_a;
        b_req_ready = grant_b;
        if (grant_a || grant_b) begin
          id_d    = grant_b;
          last_d  = grant_b;
          cnt_d   = grant_b ? b_req_n : a_req_n;
          x_d     = '0;
          y_d     = W'(1);
          state_d = CALC;
`ifdef FIB_OVF_DETECT_EN
          xt_d    = 1'b0;
          yt_d    = 1'b0;
`endif
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = x_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef FIB_OVF_DETECT_EN
          rsp_ovf_d   = xt_q;
`endif
        end else begin
          x_d   = y_q;
          y_d   = sum[W-1:0];
          cnt_d = cnt_q - NW'(1);
`ifdef FIB_OVF_DETECT_EN
          // Tag on y is sticky: any earlier wrap poisons every later term.
          xt_d  = yt_q;
          yt_d  = sum[W] | xt_q | yt_q;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef FIB_OVF_DETECT_EN
      xt_q        <= 1'b0;
      yt_q        <= 1'b0;
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef FIB_OVF_DETECT_EN
      xt_q        <= xt_d;
      yt_q        <= yt_d;
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
`ifdef FIB_OVF_DETECT_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Shared Fibonacci compute engine serving two requesters (A, B) that each ask for F(n).
- Arbitrates requests round-robin and runs one single-rate iteration engine for n steps.
- Returns the result on one shared response channel tagged with the requester id.
- Sits between control clients and the Fibonacci datapath. It sequences the datapath, so clients never drive it directly.

Parameters:
- W, 16, result/datapath width; all arithmetic is modulo 2^W.
- NW, 5, width of index n; maximum index 2^NW-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- a_req_valid  input  1  requester A has a job
- a_req_ready  output  1  A job accepted this cycle
- a_req_n  input  NW  index requested by A
- b_req_valid  input  1  requester B has a job
- b_req_ready  output  1  B job accepted this cycle
- b_req_n  input  NW  index requested by B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  0 = A, 1 = B
- rsp_data  output  W  F(n) mod 2^W
- busy  output  1  high in CALC or RESP

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Sequence definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- FSM states: IDLE, CALC, RESP.
- Reset: state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, round-robin pointer last_served=B (A wins first tie).
  - Reset mid-operation aborts the job; no response is ever produced for it.
- IDLE:
  - a_req_ready/b_req_ready are combinational and asserted only in IDLE, for the granted requester only.
  - Grant rule: only one valid -> grant it. Both valid -> grant the requester not equal to last_served.
  - On the accept edge: latch id, set cnt=n, x=0, y=1, last_served=id, go to CALC.
  - No valid request -> stay in IDLE.
- CALC:
  - If cnt==0: rsp_data<=x, rsp_valid<=1, go to RESP.
  - Else: {x,y}<={y, x+y} (W-bit, carry discarded), cnt<=cnt-1.
  - Latency: with acceptance at edge E0, rsp_valid goes high after edge E0+n+1. For n=0 that is after E0+1.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready.
  - On handshake: rsp_valid<=0, go to IDLE.
  - No request is accepted in RESP or CALC. The next acceptance happens at the earliest one cycle after the response handshake, in IDLE.
- Requesters must hold valid and n stable until ready. The scheduler does not queue requests.
- rsp_data retains its last value while rsp_valid=0.
- Maximum index 2^NW-1 is legal; results wrap modulo 2^W.
- Fairness: with both requesters continuously valid, grants alternate A, B, A, B...

Optional Feature:
- Macro: FIB_OVF_DETECT_EN.
- Defined:
  - Adds output rsp_ovf (1 bit). x and y each carry a sticky overflow tag.
  - The tag on y is set when the x+y carry-out is 1, or when either operand's tag is set. x inherits y's tag on each shift.
  - rsp_ovf equals x's tag at the CALC->RESP transition and is held with rsp_data.
  - rsp_ovf resets to 0, and tags clear on job accept.
  - rsp_ovf=1 exactly when true F(n) >= 2^W.
- Undefined: no rsp_ovf port and no tag logic; behaviour otherwise identical.

Test Plan:
- Reset, then A requests n=0 with rsp_ready=1 -> rsp_valid after 1 cycle; rsp_data=0, rsp_id=0; rsp_ovf=0 if FIB_OVF_DETECT_EN is defined.
- A requests n=10 -> rsp_valid exactly 11 cycles after acceptance; rsp_data=55, rsp_id=0, busy high throughout.
- A and B both valid after reset, with n=24 and n=1 -> A granted first and returns 46368. Then B is granted and returns 1. Grants alternate over 4 further back-to-back jobs.
- B requests n=25 (W=16) -> rsp_data=9489 (75025 mod 65536); rsp_ovf=1 if FIB_OVF_DETECT_EN is defined, and n=24 gives rsp_ovf=0.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; a_req_ready and b_req_ready stay 0 despite valid requests.
- rst asserted mid-CALC on an n=20 job -> next cycle IDLE with all outputs 0. No response appears, and a new A n=3 job returns 2.
